// File: rtl/rr_arb_pkg.sv
// Shared types and elaboration helpers for the round-robin arbiter.
`default_nettype none

package rr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Constant-safe ceil(log2(v)); returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int onehot_to_idx(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// Rotating find-first: first set req bit scanning ptr, ptr+1, ... modulo NUM_REQ.
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr is always < NUM_REQ, so one conditional subtract wraps correctly
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant and grant tenure.
// Define RR_HOLD_LIMIT_EN to bound a held tenure to MAX_HOLD cycles while others wait.
`default_nettype none

module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                                             axis_clk,
  input  logic                                             axis_reset,
  input  logic [NUM_REQ-1:0]                               req,
  output logic [NUM_REQ-1:0]                               gnt,
  output logic                                             gnt_valid,
  output logic [((clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ))-1:0] gnt_idx
);

  localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     pick_ptr_nxt;
  logic [NUM_REQ-1:0]   pick_gnt;

`ifdef RR_HOLD_LIMIT_EN
  localparam int HOLD_W = (clog2(MAX_HOLD + 1) < 1) ? 1 : clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]    hold_q, hold_d;
`else
  logic                 unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_ptr_nxt = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign pick_gnt     = NUM_REQ'(1) << pick_idx;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
`ifdef RR_HOLD_LIMIT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          ptr_d   = pick_ptr_nxt;
`ifdef RR_HOLD_LIMIT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          // Owner released: ptr already sits past the owner, so the pick is the next in turn
          if (pick_found) begin
            gnt_d = pick_gnt;
            idx_d = pick_idx;
            ptr_d = pick_ptr_nxt;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
`ifdef RR_HOLD_LIMIT_EN
          hold_d = '0;
`endif
        end else begin
`ifdef RR_HOLD_LIMIT_EN
          if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
            hold_d = '0;
            // Owner is scanned last from ptr, so a different pick means someone else waits
            if ((req & ~gnt_q) != '0) begin
              gnt_d = pick_gnt;
              idx_d = pick_idx;
              ptr_d = pick_ptr_nxt;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
`ifdef RR_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
`ifdef RR_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;

endmodule

`default_nettype wire
